// File: rtl/hwpe_ctrl_ucode_stream.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_ucode_stream
//
// Microcode-driven nested-loop address streamer. A run walks NB_LOOPS nested
// loop counters (loop 0 innermost). Every loop-index combination produces one
// output beat, carrying the current indices and the writable offset registers.
// Between two beats, the block of microcode ops attached to the incremented
// loop level runs one op per cycle. Each op is MOV/ADD/SUB/NOP on the offset
// registers, and it can read the writable or the read-only registers.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   test_mode_i           unused
//   clear_i               synchronous soft clear (highest priority)
//   start_i               launch a run (ignored while busy_o)
//   range_i               iterations per loop (0 behaves as 1)
//   loop_addr_i           first microcode slot of each loop's op block
//   loop_nb_ops_i         number of ops in each loop's op block
//   code_op_i/a_i/b_i     microcode: opcode, destination, source index
//   registers_read_i      read-only registers (indices NB_REG and up)
//   valid_o / ready_i     output beat handshake
//   offs_o, idx_o         writable registers and loop indices of the beat
//   loop_o, last_o        level stepped for this beat, final beat flag
//   busy_o, done_o        run in progress, one-cycle completion pulse
// ---------------------------------------------------------------------------
module hwpe_ctrl_ucode_stream #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned LENGTH    = 32,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_RO_REG = 28,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned AW        = $clog2(LENGTH),
  parameter int unsigned RW        = $clog2(NB_REG + NB_RO_REG),
  parameter int unsigned LW        = $clog2(NB_LOOPS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 test_mode_i,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   range_i,
  input  logic [NB_LOOPS-1:0][AW-1:0]          loop_addr_i,
  input  logic [NB_LOOPS-1:0][AW:0]            loop_nb_ops_i,
  input  logic [LENGTH-1:0][1:0]               code_op_i,
  input  logic [LENGTH-1:0][RW-1:0]            code_a_i,
  input  logic [LENGTH-1:0][RW-1:0]            code_b_i,
  input  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]  registers_read_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [NB_REG-1:0][REG_WIDTH-1:0]     offs_o,
  output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   idx_o,
  output logic [LW-1:0]                        loop_o,
  output logic                                 last_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    EXEC = 2'd2
  } state_e;

  typedef logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]  idx_t;
  typedef logic [NB_REG-1:0][REG_WIDTH-1:0]    regs_t;
  typedef logic [NB_RO_REG-1:0][REG_WIDTH-1:0] ro_t;

  state_e           state_q, state_d;
  idx_t             idx_q, idx_d, idx_step;
  regs_t            regs_q, regs_d, regs_exec;
  logic [LW-1:0]    loop_q, loop_d, step_lvl;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [REG_WIDTH-1:0] op_src;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Highest index a loop reaches; a range of 0 behaves like a range of 1.
  function automatic logic [CNT_WIDTH-1:0] top_idx(input logic [CNT_WIDTH-1:0] rng);
    return (rng == {CNT_WIDTH{1'b0}}) ? {CNT_WIDTH{1'b0}} : (rng - CNT_WIDTH'(1));
  endfunction

  // The final beat is the one where every loop sits at its top index.
  function automatic logic at_last(input idx_t idx, input idx_t rng);
    logic l;
    l = 1'b1;
    for (int k = 0; k < int'(NB_LOOPS); k++) begin
      l = l & (idx[k] == top_idx(rng[k]));
    end
    return l;
  endfunction

  // Source operand: writable registers first, then read-only ones, else zero.
  function automatic logic [REG_WIDTH-1:0] src_val(input logic [RW-1:0] b,
                                                   input regs_t regs, input ro_t ro);
    logic [REG_WIDTH-1:0] v;
    v = {REG_WIDTH{1'b0}};
    for (int j = 0; j < int'(NB_REG); j++) begin
      v = (int'(b) == j) ? regs[j] : v;
    end
    for (int j = 0; j < int'(NB_RO_REG); j++) begin
      v = (int'(b) == int'(NB_REG) + j) ? ro[j] : v;
    end
    return v;
  endfunction

  // Level to step: the lowest loop not yet at its top (scan downward, last hit wins).
  always_comb begin
    step_lvl = {LW{1'b0}};
    for (int k = int'(NB_LOOPS) - 1; k >= 0; k--) begin
      if (idx_q[k] < top_idx(range_i[k])) begin
        step_lvl = LW'(k);
      end else begin
        step_lvl = step_lvl;
      end
    end
  end

  // Indices after stepping: the stepped level counts up, inner levels restart.
  always_comb begin
    idx_step = idx_q;
    for (int k = 0; k < int'(NB_LOOPS); k++) begin
      if (LW'(k) < step_lvl) begin
        idx_step[k] = {CNT_WIDTH{1'b0}};
      end else if (LW'(k) == step_lvl) begin
        idx_step[k] = idx_q[k] + CNT_WIDTH'(1);
      end else begin
        idx_step[k] = idx_q[k];
      end
    end
  end

  // Result of the op at the current pointer; destinations past NB_REG are dropped.
  always_comb begin
    op_src    = src_val(code_b_i[ptr_q], regs_q, registers_read_i);
    regs_exec = regs_q;
    for (int j = 0; j < int'(NB_REG); j++) begin
      if (int'(code_a_i[ptr_q]) == j) begin
        case (code_op_i[ptr_q])
          2'd0:    regs_exec[j] = op_src;
          2'd1:    regs_exec[j] = regs_q[j] + op_src;
          2'd2:    regs_exec[j] = regs_q[j] - op_src;
          default: regs_exec[j] = regs_q[j];
        endcase
      end else begin
        regs_exec[j] = regs_q[j];
      end
    end
  end

  // Next-state logic for the IDLE/EMIT/EXEC controller.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    loop_d  = loop_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = {NB_LOOPS*CNT_WIDTH{1'b0}};
      regs_d  = {NB_REG*REG_WIDTH{1'b0}};
      loop_d  = {LW{1'b0}};
      ptr_d   = {AW{1'b0}};
      rem_d   = {(AW+1){1'b0}};
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = EMIT;
            idx_d   = {NB_LOOPS*CNT_WIDTH{1'b0}};
            regs_d  = {NB_REG*REG_WIDTH{1'b0}};
            loop_d  = {LW{1'b0}};
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        EMIT: begin
          if (valid_q && ready_i) begin
            if (last_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_step;
              loop_d = step_lvl;
              if (loop_nb_ops_i[step_lvl] == {(AW+1){1'b0}}) begin
                // Empty op block: the next beat follows immediately.
                state_d = EMIT;
                valid_d = 1'b1;
              end else begin
                state_d = EXEC;
                valid_d = 1'b0;
                ptr_d   = loop_addr_i[step_lvl];
                rem_d   = loop_nb_ops_i[step_lvl];
              end
            end
          end else begin
            state_d = EMIT;
          end
        end
        EXEC: begin
          regs_d = regs_exec;
          ptr_d  = (ptr_q == AW'(LENGTH - 1)) ? {AW{1'b0}} : (ptr_q + AW'(1));
          rem_d  = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) begin
            state_d = EMIT;
            valid_d = 1'b1;
          end else begin
            state_d = EXEC;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Status flags registered alongside the beat they describe.
  always_comb begin
    busy_d = (state_d != IDLE);
    if (state_d == EMIT) begin
      last_d = at_last(idx_d, range_i);
    end else begin
      last_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= {NB_LOOPS*CNT_WIDTH{1'b0}};
      regs_q  <= {NB_REG*REG_WIDTH{1'b0}};
      loop_q  <= {LW{1'b0}};
      ptr_q   <= {AW{1'b0}};
      rem_q   <= {(AW+1){1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      loop_q  <= loop_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign offs_o  = regs_q;
  assign idx_o   = idx_q;
  assign loop_o  = loop_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_hwpe_ctrl_ucode_stream.sv
// ---------------------------------------------------------------------------
// tb_hwpe_ctrl_ucode_stream
//
// Self-checking bench for hwpe_ctrl_ucode_stream with default parameters.
// For every run, a reference model enumerates the beats: the beat number is
// decoded in mixed radix over the loop ranges, and the op blocks are replayed
// on a plain register array. DUT beats are then compared with these beats as
// they are accepted.
// ---------------------------------------------------------------------------
module tb_hwpe_ctrl_ucode_stream;

  localparam int NL = 6, LEN = 32, NR = 4, NRO = 28, RWD = 32, CW = 16;
  localparam int AW = 5, RW = 5, LW = 3;

  typedef logic [NL-1:0][CW-1:0] idx_t;
  typedef logic [NR-1:0][RWD-1:0] regs_t;
  typedef struct {
    idx_t          idx;
    regs_t         offs;
    logic [LW-1:0] loop;
    logic          last;
    int            gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst_ni, test_mode_i, clear_i, start_i, ready_i;
  logic [NL-1:0][CW-1:0]    range_i;
  logic [NL-1:0][AW-1:0]    loop_addr_i;
  logic [NL-1:0][AW:0]      loop_nb_ops_i;
  logic [LEN-1:0][1:0]      code_op_i;
  logic [LEN-1:0][RW-1:0]   code_a_i, code_b_i;
  logic [NRO-1:0][RWD-1:0]  registers_read_i;
  logic                     valid_o, last_o, busy_o, done_o;
  regs_t                    offs_o;
  idx_t                     idx_o;
  logic [LW-1:0]            loop_o;

  beat_t          exp_q[$];
  logic [RWD-1:0] r0_seen[$];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_ucode_stream dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .start_i(start_i), .range_i(range_i), .loop_addr_i(loop_addr_i),
    .loop_nb_ops_i(loop_nb_ops_i), .code_op_i(code_op_i), .code_a_i(code_a_i),
    .code_b_i(code_b_i), .registers_read_i(registers_read_i), .valid_o(valid_o),
    .ready_i(ready_i), .offs_o(offs_o), .idx_o(idx_o), .loop_o(loop_o),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One microcode op applied to the register array.
  function automatic regs_t exec_op(input regs_t r, input int p);
    int a, b;
    logic [RWD-1:0] s;
    a = int'(code_a_i[p]);
    b = int'(code_b_i[p]);
    if (b < NR) s = r[b];
    else if (b < NR + NRO) s = registers_read_i[b - NR];
    else s = 32'd0;
    if (a < NR) begin
      case (code_op_i[p])
        2'd0: r[a] = s;
        2'd1: r[a] = r[a] + s;
        2'd2: r[a] = r[a] - s;
        default: r[a] = r[a];
      endcase
    end
    return r;
  endfunction

  // Beat list for the current configuration.
  task automatic build_model();
    int eff[NL];
    int total, rem, lvl, p;
    idx_t idx;
    regs_t regs;
    beat_t b;
    exp_q.delete();
    total = 1;
    for (int k = 0; k < NL; k++) begin
      eff[k] = (range_i[k] == 16'd0) ? 1 : int'(range_i[k]);
      total = total * eff[k];
    end
    regs = '0;
    for (int n = 0; n < total; n++) begin
      rem = n;
      for (int k = 0; k < NL; k++) begin
        idx[k] = CW'(rem % eff[k]);
        rem = rem / eff[k];
      end
      lvl = 0;
      b.gap = 1;
      if (n > 0) begin
        lvl = -1;
        for (int k = 0; k < NL; k++) if (lvl < 0 && idx[k] != 16'd0) lvl = k;
        p = int'(loop_addr_i[lvl]);
        for (int j = 0; j < int'(loop_nb_ops_i[lvl]); j++) begin
          regs = exec_op(regs, p);
          p = (p + 1) % LEN;
        end
        b.gap = int'(loop_nb_ops_i[lvl]) + 1;
      end
      b.idx = idx;
      b.offs = regs;
      b.loop = LW'(lvl);
      b.last = (n == total - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_cfg();
    range_i = '0;
    loop_addr_i = '0;
    loop_nb_ops_i = '0;
    code_op_i = {LEN{2'd3}};
    code_a_i = '0;
    code_b_i = '0;
    registers_read_i = '0;
  endtask

  // Full run: mode 0 ready high, 1 ready toggling, 2 ready random.
  task automatic run_check(input string name, input int mode);
    int cyc, beats, last_hs, remaining;
    beat_t e;
    regs_t final_offs;
    build_model();
    r0_seen.delete();
    final_offs = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({name, "/first_valid"}, valid_o, 1);
    chk({name, "/busy"}, busy_o, 1);
    cyc = 0;
    beats = 0;
    last_hs = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      case (mode)
        0: ready_i = 1'b1;
        1: ready_i = (cyc % 2 == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      if (valid_o) begin
        e = exp_q[0];
        chk($sformatf("%s/b%0d/idx", name, beats), idx_o, e.idx);
        chk($sformatf("%s/b%0d/offs", name, beats), offs_o, e.offs);
        chk($sformatf("%s/b%0d/loop", name, beats), loop_o, e.loop);
        chk($sformatf("%s/b%0d/last", name, beats), last_o, e.last);
        if (ready_i) begin
          if (mode == 0 && beats > 0)
            chk($sformatf("%s/b%0d/gap", name, beats), cyc - last_hs, e.gap);
          r0_seen.push_back(offs_o[0]);
          final_offs = e.offs;
          void'(exp_q.pop_front());
          beats++;
          last_hs = cyc;
        end
      end
      tick();
      cyc++;
    end
    ready_i = 1'b0;
    remaining = exp_q.size();
    chk({name, "/beats_left"}, remaining, 0);
    chk({name, "/done"}, done_o, 1);
    chk({name, "/idle"}, {busy_o, valid_o}, 2'b00);
    chk({name, "/held_offs"}, offs_o, final_offs);
    tick();
    chk({name, "/done_pulse"}, done_o, 0);
  endtask

  task automatic cfg_basic();
    clear_cfg();
    range_i[0] = 16'd3;
    range_i[1] = 16'd2;
    loop_nb_ops_i[0] = 6'd1;
    loop_nb_ops_i[1] = 6'd1;
    loop_addr_i[0] = 5'd0;
    loop_addr_i[1] = 5'd1;
    code_op_i[0] = 2'd1; code_a_i[0] = 5'd0; code_b_i[0] = 5'd4;
    code_op_i[1] = 2'd0; code_a_i[1] = 5'd0; code_b_i[1] = 5'd1;
    registers_read_i[0] = 32'd4;
  endtask

  initial begin
    logic [RWD-1:0] r0_ref[6];
    r0_ref = '{32'd0, 32'd4, 32'd8, 32'd0, 32'd4, 32'd8};
    rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    clear_cfg();
    tick();
    tick();
    chk("reset/outs", {valid_o, last_o, done_o, busy_o, loop_o, offs_o, idx_o}, '0);
    rst_ni = 1'b1;
    tick();

    // Two nested loops, ready held high, r0 sequence against fixed values.
    cfg_basic();
    run_check("basic", 0);
    chk("basic/nbeats", r0_seen.size(), 6);
    for (int i = 0; i < 6 && i < r0_seen.size(); i++)
      chk($sformatf("basic/r0_%0d", i), r0_seen[i], r0_ref[i]);

    // Same config with ready toggling.
    run_check("toggle", 1);

    // All ranges one.
    clear_cfg();
    range_i[2] = 16'd1;
    run_check("single", 0);

    // No ops: back-to-back beats.
    clear_cfg();
    range_i[0] = 16'd4;
    run_check("noops", 0);

    // SUB wrap, NOP destination, pointer wrap, op chaining.
    clear_cfg();
    range_i[0] = 16'd2;
    loop_addr_i[0] = 5'd30;
    loop_nb_ops_i[0] = 6'd3;
    code_op_i[30] = 2'd2; code_a_i[30] = 5'd0; code_b_i[30] = 5'd4;
    code_op_i[31] = 2'd1; code_a_i[31] = 5'd4; code_b_i[31] = 5'd5;
    code_op_i[0]  = 2'd0; code_a_i[0]  = 5'd1; code_b_i[0]  = 5'd0;
    registers_read_i[0] = 32'd1;
    registers_read_i[1] = 32'd7;
    run_check("wrap", 0);
    chk("wrap/r0", offs_o[0], 32'hFFFF_FFFF);
    chk("wrap/r1", offs_o[1], 32'hFFFF_FFFF);
    chk("wrap/r3r2", {offs_o[3], offs_o[2]}, 64'd0);

    // Clear on beat 3, then replay.
    cfg_basic();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ready_i = 1'b1;
    tick(); tick(); tick(); tick();
    chk("clr/beat3_valid", valid_o, 1);
    chk("clr/beat3_r0", offs_o[0], 32'd8);
    clear_i = 1'b1;
    ready_i = 1'b0;
    tick();
    clear_i = 1'b0;
    chk("clr/state", {busy_o, done_o, valid_o}, 3'b000);
    chk("clr/offs", offs_o, '0);
    chk("clr/idx", idx_o, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("clr/quiet%0d", i), {valid_o, done_o}, 2'b00);
    end
    run_check("replay", 0);

    // Clear and start together: start dropped.
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("clrstart/idle", {busy_o, valid_o}, 2'b00);
    tick();
    chk("clrstart/still_idle", {busy_o, valid_o}, 2'b00);

    // Asynchronous reset mid-run.
    cfg_basic();
    ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    #2 rst_ni = 1'b0;
    #1 chk("rstmid/outs", {valid_o, last_o, done_o, busy_o, loop_o, offs_o, idx_o}, '0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstmid/quiet%0d", i), {valid_o, done_o, busy_o}, 3'b000);
    end
    ready_i = 1'b0;

    // Randomized configurations.
    for (int it = 0; it < 6; it++) begin
      clear_cfg();
      for (int k = 0; k < 3; k++) range_i[k] = CW'($urandom_range(0, 3));
      for (int k = 3; k < NL; k++) range_i[k] = CW'($urandom_range(0, 1));
      for (int k = 0; k < NL; k++) begin
        loop_addr_i[k] = AW'($urandom_range(0, LEN - 1));
        loop_nb_ops_i[k] = 6'($urandom_range(0, 4));
      end
      for (int p = 0; p < LEN; p++) begin
        code_op_i[p] = 2'($urandom_range(0, 3));
        code_a_i[p] = RW'($urandom_range(0, 7));
        code_b_i[p] = RW'($urandom_range(0, 31));
      end
      for (int j = 0; j < NRO; j++) registers_read_i[j] = $urandom;
      run_check($sformatf("rand%0d", it), it % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_ucode_stream.md
HWPE_CTRL_UCODE_STREAM -- requirements
Module: hwpe_ctrl_ucode_stream

Interface
REQ-001 Parameter NB_LOOPS, default 6, number of nested loops; loop 0 is innermost.
REQ-002 Parameter LENGTH, default 32, number of microcode op slots.
REQ-003 Parameter NB_REG, default 4, writable offset registers.
REQ-004 Parameter NB_RO_REG, default 28, read-only registers.
REQ-005 Parameter REG_WIDTH, default 32; CNT_WIDTH, default 16.
REQ-006 Derived widths: AW = $clog2(LENGTH); RW = $clog2(NB_REG+NB_RO_REG); LW = $clog2(NB_LOOPS).
REQ-007 clk_i  in  1  clock; all state on rising edge.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 test_mode_i  in  1  unused, no functional effect.
REQ-010 clear_i  in  1  synchronous soft clear.
REQ-011 start_i  in  1  launch a run; ignored while busy_o=1.
REQ-012 range_i  in  NB_LOOPS x CNT_WIDTH  iterations per loop; value 0 treated as 1.
REQ-013 loop_addr_i  in  NB_LOOPS x AW  first op slot of each loop's block.
REQ-014 loop_nb_ops_i  in  NB_LOOPS x (AW+1)  ops in each loop's block; 0 is legal.
REQ-015 code_op_i  in  LENGTH x 2  opcode: 0 MOV, 1 ADD, 2 SUB, 3 NOP.
REQ-016 code_a_i, code_b_i  in  LENGTH x RW each  destination/source register index.
REQ-017 registers_read_i  in  NB_RO_REG x REG_WIDTH  read-only registers, indices NB_REG..NB_REG+NB_RO_REG-1.
REQ-018 valid_o  out  1  output beat valid; ready_i  in  1  consumer accepts.
REQ-019 offs_o  out  NB_REG x REG_WIDTH  current writable registers.
REQ-020 idx_o  out  NB_LOOPS x CNT_WIDTH  current loop indices.
REQ-021 loop_o  out  LW  level incremented to produce this beat, 0 for the first beat; last_o  out  1  final beat of the run.
REQ-022 busy_o  out  1  run in progress; done_o  out  1  one-cycle completion pulse.

Function
REQ-023 FSM states IDLE, EMIT, EXEC; busy_o = (state != IDLE).
REQ-024 IDLE with start_i=1: clear all idx and registers to 0 and go to EMIT; valid_o rises on the next cycle.
REQ-025 EMIT: valid_o=1; offs_o, idx_o, loop_o and last_o are registered and stable until the handshake (valid_o & ready_i).
REQ-026 last_o=1 iff every idx[k] = eff_range[k]-1.
REQ-027 Handshake with last_o=1: go to IDLE, pulse done_o for one cycle, hold idx and registers.
REQ-028 Handshake with last_o=0: L = lowest k with idx[k] < eff_range[k]-1; idx[L]++, idx[0..L-1] := 0, loop_o := L.
REQ-029 After the step in REQ-028: if loop_nb_ops_i[L] = 0, stay in EMIT with a new beat the next cycle; otherwise go to EXEC with pointer = loop_addr_i[L] and remaining ops = loop_nb_ops_i[L].
REQ-030 EXEC: one op per cycle, and the pointer increments modulo LENGTH.
REQ-031 When the last op of the block executes, go to EMIT.
REQ-032 valid_o=0 throughout EXEC.
REQ-033 Op semantics with S = source register b: MOV sets a := S; ADD sets a := a + S; SUB sets a := a - S; arithmetic wraps modulo 2^REG_WIDTH.
REQ-034 An op with a >= NB_REG is a NOP; a source index >= NB_REG+NB_RO_REG reads 0.
REQ-035 Each op sees the results of earlier ops in the same block.
REQ-036 With ready_i held high, beat spacing is loop_nb_ops_i[L]+1 cycles.
REQ-037 A run emits exactly prod(eff_range) beats.
REQ-038 Config inputs and registers_read_i are sampled live and must be held stable while busy; changes mid-run are undefined.
REQ-039 clear_i=1 has priority over all else: go to IDLE, clear idx, registers and valid_o, no done_o pulse.
REQ-040 clear_i and start_i in the same cycle: the clear wins and start_i is dropped.

Reset
REQ-041 rst_ni=0 asynchronously forces IDLE: valid_o, last_o, done_o, busy_o, loop_o, offs_o and idx_o are all 0.
REQ-042 Reset deasserted mid-run: no beat and no done_o pulse until a new start_i.

Verification
REQ-043 NB_LOOPS=2, range={3,2}, nb_ops={1,1}, loop0 op ADD r0+=ro0 with ro0=4, loop1 op MOV r0:=r1 (r1=0), ready=1 -> 6 beats, r0 = 0,4,8,0,4,8, last_o on beat 6, done_o one cycle later.
REQ-044 Same config, ready_i toggling 1/0 -> identical beat sequence, and outputs held while valid_o & ~ready_i.
REQ-045 All ranges 1 -> one beat with idx all 0 and last_o=1, then done_o.
REQ-046 nb_ops all 0, range={4,1,...} -> 4 consecutive beats with valid_o high and idx0 = 0..3.
REQ-047 SUB r0 -= ro0 with r0=0 and ro0=1 -> r0 = 0xFFFFFFFF (wrap); an op with a=NB_REG leaves all offs_o unchanged.
REQ-048 clear_i pulsed on beat 3 -> busy_o=0 the next cycle, no done_o, offs_o=0; a new start_i replays from beat 1.
